// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage_if
// Description : Bundle of the signals crossing the execute stage. It carries
//               the ID/EX register contents into the stage and the EX/MEM
//               register contents out of it.
//                 slave  - the execute stage: reads the ID/EX bundle, drives
//                          the EX/MEM outputs.
//                 master - the environment: drives the ID/EX bundle, stall
//                          and flush, and observes the EX/MEM outputs.
//               Ports carried (ID/EX side): stall, flush, alu_data, rs, rt,
//               sign_extend_inp, rt_address, rd_address, regDest, jump,
//               branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp.
//               Ports carried (EX/MEM side): alu_result_out, store_data_out,
//               branch_target_out, write_reg_out, zero_out, overflow_out,
//               branch_taken_out, jump_out, MemRead_out, MemtoReg_out,
//               MemWrite_out, RegWrite_out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Hazard-unit controls
  logic              stall;
  logic              flush;

  // ID/EX bundle
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic [DATA_W-1:0] sign_extend_inp;
  logic [REG_AW-1:0] rt_address;
  logic [REG_AW-1:0] rd_address;
  logic              regDest;
  logic              jump;
  logic              branch;
  logic              MemRead;
  logic              MemtoReg;
  logic              MemWrite;
  logic              ALUSrc;
  logic              RegWrite;
  logic [1:0]        ALUOp;

  // EX/MEM bundle
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] store_data_out;
  logic [DATA_W-1:0] branch_target_out;
  logic [REG_AW-1:0] write_reg_out;
  logic              zero_out;
  logic              overflow_out;
  logic              branch_taken_out;
  logic              jump_out;
  logic              MemRead_out;
  logic              MemtoReg_out;
  logic              MemWrite_out;
  logic              RegWrite_out;

  modport slave (
    input  stall, flush,
    input  alu_data, rs, rt, sign_extend_inp, rt_address, rd_address,
    input  regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc,
    input  RegWrite, ALUOp,
    output alu_result_out, store_data_out, branch_target_out, write_reg_out,
    output zero_out, overflow_out, branch_taken_out, jump_out, MemRead_out,
    output MemtoReg_out, MemWrite_out, RegWrite_out
  );

  modport master (
    output stall, flush,
    output alu_data, rs, rt, sign_extend_inp, rt_address, rd_address,
    output regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc,
    output RegWrite, ALUOp,
    input  alu_result_out, store_data_out, branch_target_out, write_reg_out,
    input  zero_out, overflow_out, branch_taken_out, jump_out, MemRead_out,
    input  MemtoReg_out, MemWrite_out, RegWrite_out
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : Execute stage plus EX/MEM pipeline register. Decodes the ALU
//               control from ALUOp/funct, runs the ALU, selects the
//               destination register, computes the branch target and
//               captures everything into EX/MEM one cycle later. Supports
//               hold (stall) and bubble insertion (flush, wins over stall).
//               Ports:
//                 clk   - rising-edge clock
//                 reset - asynchronous active-high clear of all state
//                 bus   - ex_mem_stage_if.slave: ID/EX bundle in, hazard
//                         controls in, EX/MEM bundle out
//               Only DATA_W = 32 is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  wire logic           clk,
  input  wire logic           reset,
  ex_mem_stage_if.slave       bus
);

  // --------------------------------------------------------------------------
  // ALU operation encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_AND = 3'd2;
  localparam logic [2:0] c_OP_OR  = 3'd3;
  localparam logic [2:0] c_OP_NOR = 3'd4;
  localparam logic [2:0] c_OP_SLT = 3'd5;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_NOR = 6'h27;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  localparam int c_MSB = DATA_W - 1;

  // --------------------------------------------------------------------------
  // Combinational execute datapath
  // --------------------------------------------------------------------------
  logic [5:0]        w_funct;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;
  logic              w_slt;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_zero;
  logic [DATA_W-1:0] w_branch_target;
  logic [REG_AW-1:0] w_write_reg;

  assign w_funct = bus.sign_extend_inp[5:0];
  assign w_a     = bus.rs;
  assign w_b     = bus.ALUSrc ? bus.sign_extend_inp : bus.rt;

  // ALU control decode
  always_comb begin
    w_op = c_OP_ADD;
    case (bus.ALUOp)
      2'b00: w_op = c_OP_ADD;
      2'b01: w_op = c_OP_SUB;
      2'b11: w_op = c_OP_OR;
      default: begin
        case (w_funct)
          c_FN_ADD: w_op = c_OP_ADD;
          c_FN_SUB: w_op = c_OP_SUB;
          c_FN_AND: w_op = c_OP_AND;
          c_FN_OR:  w_op = c_OP_OR;
          c_FN_NOR: w_op = c_OP_NOR;
          c_FN_SLT: w_op = c_OP_SLT;
          default:  w_op = c_OP_ADD;
        endcase
      end
    endcase
  end

  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  // Signed overflow from the operand and result sign bits
  assign w_add_ovf = (w_a[c_MSB] == w_b[c_MSB]) && (w_sum[c_MSB]  != w_a[c_MSB]);
  assign w_sub_ovf = (w_a[c_MSB] != w_b[c_MSB]) && (w_diff[c_MSB] != w_a[c_MSB]);

  // Signed less-than reuses the subtractor: the true sign of (a - b) is the
  // wrapped sign bit corrected by the overflow flag.
  assign w_slt = w_diff[c_MSB] ^ w_sub_ovf;

  always_comb begin
    w_result = w_sum;
    w_ovf    = 1'b0;
    case (w_op)
      c_OP_ADD: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      c_OP_SUB: begin
        w_result = w_diff;
        w_ovf    = w_sub_ovf;
      end
      c_OP_AND: w_result = w_a & w_b;
      c_OP_OR:  w_result = w_a | w_b;
      c_OP_NOR: w_result = ~(w_a | w_b);
      c_OP_SLT: w_result = {{(DATA_W-1){1'b0}}, w_slt};
      default: begin
        w_result = w_sum;
        w_ovf    = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_result == '0);

  // Word offset to byte offset; the two bits shifted out at the top are lost
  assign w_branch_target = bus.alu_data + {bus.sign_extend_inp[DATA_W-3:0], 2'b00};

  assign w_write_reg = bus.regDest ? bus.rd_address : bus.rt_address;

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_branch_target;
  logic [REG_AW-1:0] r_write_reg;
  logic              r_zero;
  logic              r_overflow;
  logic              r_branch_taken;
  logic              r_jump;
  logic              r_mem_read;
  logic              r_mem_to_reg;
  logic              r_mem_write;
  logic              r_reg_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_branch_target <= '0;
      r_write_reg     <= '0;
      r_zero          <= 1'b0;
      r_overflow      <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_jump          <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
    end else if (bus.flush) begin
      // Bubble: flush beats stall so a squashed instruction never lingers
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_branch_target <= '0;
      r_write_reg     <= '0;
      r_zero          <= 1'b0;
      r_overflow      <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_jump          <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
    end else if (!bus.stall) begin
      r_alu_result    <= w_result;
      r_store_data    <= bus.rt;
      r_branch_target <= w_branch_target;
      r_write_reg     <= w_write_reg;
      r_zero          <= w_zero;
      r_overflow      <= w_ovf;
      // Taken-ness comes from this instruction's own zero, not the held r_zero
      r_branch_taken  <= bus.branch & w_zero;
      r_jump          <= bus.jump;
      r_mem_read      <= bus.MemRead;
      r_mem_to_reg    <= bus.MemtoReg;
      r_mem_write     <= bus.MemWrite;
      r_reg_write     <= bus.RegWrite;
    end
  end

  assign bus.alu_result_out    = r_alu_result;
  assign bus.store_data_out    = r_store_data;
  assign bus.branch_target_out = r_branch_target;
  assign bus.write_reg_out     = r_write_reg;
  assign bus.zero_out          = r_zero;
  assign bus.overflow_out      = r_overflow;
  assign bus.branch_taken_out  = r_branch_taken;
  assign bus.jump_out          = r_jump;
  assign bus.MemRead_out       = r_mem_read;
  assign bus.MemtoReg_out      = r_mem_to_reg;
  assign bus.MemWrite_out      = r_mem_write;
  assign bus.RegWrite_out      = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage. A behavioural model
//               computes the expected EX/MEM contents from the instruction
//               semantics; a compare process checks the DUT against it every
//               falling edge, and directed vectors pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] bt;
    logic [4:0]  wr;
    logic        zero;
    logic        ovf;
    logic        taken;
    logic        jump;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        rw;
  } out_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ex_mem_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  out_t act;
  out_t exp_q = '0;

  assign act = '{alu: bus.alu_result_out, sd: bus.store_data_out,
                 bt: bus.branch_target_out, wr: bus.write_reg_out,
                 zero: bus.zero_out, ovf: bus.overflow_out,
                 taken: bus.branch_taken_out, jump: bus.jump_out,
                 mr: bus.MemRead_out, m2r: bus.MemtoReg_out,
                 mw: bus.MemWrite_out, rw: bus.RegWrite_out};

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic out_t model_next();
    out_t        o;
    logic [31:0] a, b, r;
    logic        ovf;
    longint      s;
    longint      c_max;
    longint      c_min;
    string       op;
    c_max = 2147483647;
    c_min = -c_max - 1;
    a = bus.rs;
    b = bus.ALUSrc ? bus.sign_extend_inp : bus.rt;
    case (bus.ALUOp)
      2'd0: op = "add";
      2'd1: op = "sub";
      2'd3: op = "or";
      default: begin
        case (bus.sign_extend_inp[5:0])
          6'h22:   op = "sub";
          6'h24:   op = "and";
          6'h25:   op = "or";
          6'h27:   op = "nor";
          6'h2A:   op = "slt";
          default: op = "add";
        endcase
      end
    endcase
    ovf = 1'b0;
    if (op == "add") begin
      s   = longint'($signed(a)) + longint'($signed(b));
      r   = s[31:0];
      ovf = (s > c_max) || (s < c_min);
    end else if (op == "sub") begin
      s   = longint'($signed(a)) - longint'($signed(b));
      r   = s[31:0];
      ovf = (s > c_max) || (s < c_min);
    end else if (op == "and") r = a & b;
    else if (op == "or")      r = a | b;
    else if (op == "nor")     r = ~(a | b);
    else                      r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    o.alu   = r;
    o.sd    = bus.rt;
    o.bt    = bus.alu_data + bus.sign_extend_inp * 32'd4;
    o.wr    = bus.regDest ? bus.rd_address : bus.rt_address;
    o.zero  = (r == 32'd0);
    o.ovf   = ovf;
    o.taken = bus.branch && (r == 32'd0);
    o.jump  = bus.jump;
    o.mr    = bus.MemRead;
    o.m2r   = bus.MemtoReg;
    o.mw    = bus.MemWrite;
    o.rw    = bus.RegWrite;
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)           exp_q <= '0;
    else if (bus.flush)  exp_q <= '0;
    else if (!bus.stall) exp_q <= model_next();
  end

  // Every-cycle comparison against the model
  always @(negedge clk) chk("cycle", act, exp_q);

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.alu_data = 0; bus.rs = 0; bus.rt = 0; bus.sign_extend_inp = 0;
    bus.rt_address = 0; bus.rd_address = 0;
    bus.regDest = 0; bus.jump = 0; bus.branch = 0; bus.MemRead = 0;
    bus.MemtoReg = 0; bus.MemWrite = 0; bus.ALUSrc = 0; bus.RegWrite = 0;
    bus.ALUOp = 0;
  endtask

  task automatic rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    clear_inputs();
    bus.rs = a; bus.rt = b; bus.ALUOp = 2'b10; bus.sign_extend_inp = {26'd0, fn};
    bus.regDest = 1; bus.rd_address = 5'd5; bus.rt_address = 5'd7; bus.RegWrite = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    repeat (2) tick();
    chk("reset_state", act, 128'd0);
    reset = 0;

    // R-type add with overflow: RegWrite still set
    rtype(32'h7FFF_FFFF, 32'd1, 6'h20);
    tick();
    chk("add_result", act.alu, 32'h8000_0000);
    chk("add_ovf", act.ovf, 1'b1);
    chk("add_wr", act.wr, 5'd5);
    chk("add_rw", act.rw, 1'b1);

    // slt signed, both orders
    rtype(32'hFFFF_FFFE, 32'd3, 6'h2A);
    tick();
    chk("slt_lt", act.alu, 32'd1);
    rtype(32'd3, 32'hFFFF_FFFE, 6'h2A);
    tick();
    chk("slt_ge", act.alu, 32'd0);
    chk("slt_zero", act.zero, 1'b1);

    // sub overflow, and/nor, unknown funct -> add
    rtype(32'h8000_0000, 32'd1, 6'h22);
    tick();
    chk("sub_result", act.alu, 32'h7FFF_FFFF);
    chk("sub_ovf", act.ovf, 1'b1);
    rtype(32'hF0F0_1234, 32'h0FF0_FFFF, 6'h24);
    tick();
    chk("and_result", act.alu, 32'h00F0_1234);
    rtype(32'hF0F0_0000, 32'h0000_000F, 6'h27);
    tick();
    chk("nor_result", act.alu, 32'h0F0F_FFF0);
    rtype(32'd10, 32'd20, 6'h3F);
    tick();
    chk("default_add", act.alu, 32'd30);

    // beq taken
    clear_inputs();
    bus.rs = 32'h1234; bus.rt = 32'h1234; bus.ALUOp = 2'b01; bus.branch = 1;
    bus.alu_data = 32'h100; bus.sign_extend_inp = 32'hFFFF_FFFF;
    tick();
    chk("beq_zero", act.zero, 1'b1);
    chk("beq_taken", act.taken, 1'b1);
    chk("beq_target", act.bt, 32'h0000_00FC);

    // beq not taken right after a taken one
    bus.rt = 32'h1235;
    tick();
    chk("bne_taken", act.taken, 1'b0);

    // sw with jump bit passed through
    clear_inputs();
    bus.ALUSrc = 1; bus.rs = 32'h2000; bus.sign_extend_inp = 32'hFFFF_FFFC;
    bus.rt = 32'hCAFE_BABE; bus.MemWrite = 1; bus.jump = 1;
    tick();
    chk("sw_addr", act.alu, 32'h0000_1FFC);
    chk("sw_data", act.sd, 32'hCAFE_BABE);
    chk("sw_ctl", {act.jump, act.mw, act.rw}, 3'b110);

    // lw
    clear_inputs();
    bus.ALUSrc = 1; bus.rs = 32'h1000; bus.sign_extend_inp = 32'h10;
    bus.rt_address = 5'd9; bus.rd_address = 5'd3; bus.MemRead = 1; bus.MemtoReg = 1;
    bus.RegWrite = 1;
    tick();
    chk("lw_addr", act.alu, 32'h1010);
    chk("lw_wr", act.wr, 5'd9);
    chk("lw_ctl", {act.mr, act.m2r}, 2'b11);

    // stall 3 cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      rtype(32'h1111_0000 * (i + 1), 32'd77 + i, 6'h25);
      bus.stall = 1;
      tick();
      chk("stall_alu", act.alu, 32'h1010);
      chk("stall_wr", act.wr, 5'd9);
    end

    // flush together with stall -> bubble
    bus.flush = 1;
    tick();
    chk("flush_stall", act, 128'd0);

    // release, ALUOp=11 -> or
    clear_inputs();
    bus.ALUOp = 2'b11; bus.rs = 32'hF0; bus.rt = 32'h0F; bus.RegWrite = 1;
    bus.rt_address = 5'd4;
    tick();
    chk("or_after_release", act.alu, 32'hFF);
    chk("or_wr", act.wr, 5'd4);

    // flush alone
    bus.flush = 1;
    tick();
    chk("flush_only", act, 128'd0);
    bus.flush = 0;
    tick();
    chk("post_flush", act.alu, 32'hFF);

    // asynchronous reset mid-cycle
    reset = 1;
    #1;
    chk("async_reset", act, 128'd0);
    tick();
    rtype(32'd100, 32'd23, 6'h20);
    reset = 0;
    tick();
    chk("after_reset", act.alu, 32'd123);
    chk("after_reset_rw", act.rw, 1'b1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Consumer side of the ID/EX pipeline register: takes the registered decode-stage bundle, performs the execute stage and captures the results into the EX/MEM pipeline register.
- Execute work: ALU-control decode, ALU operation, destination-register select and branch-target calculation.
- Sits between the ID/EX register and the data-memory stage.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  hold the EX/MEM contents.
- flush  in  1  load a bubble into EX/MEM.
- alu_data  in  32  PC+4 of the instruction in EX.
- rs  in  32  register operand A.
- rt  in  32  register operand B; also the store data.
- sign_extend_inp  in  32  sign-extended immediate; bits [5:0] are the funct field.
- rt_address  in  5  rt field.
- rd_address  in  5  rd field.
- regDest, jump, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  in  1 each  control bits from ID/EX.
- ALUOp  in  2  ALU class.
- alu_result_out  out  32  registered ALU result.
- store_data_out  out  32  registered rt (store data).
- branch_target_out  out  32  registered branch target.
- write_reg_out  out  5  registered destination register.
- zero_out  out  1  registered (ALU result == 0).
- overflow_out  out  1  registered signed overflow of add/sub.
- branch_taken_out  out  1  registered branch AND zero.
- jump_out, MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out  out  1 each  registered controls.

Behaviour:
- Reset: every output is 0, asynchronously and immediately. Reset asserted mid-operation discards in-flight state; the first capture after release happens on the next rising edge.
- Operand B: sign_extend_inp when ALUSrc=1, otherwise rt.
- ALU control:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 11 → or.
  - ALUOp 10 → decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt. Any other funct → add.
- Arithmetic:
  - All operations are 32-bit, wrapping modulo 2^32.
  - slt is a signed comparison; the result is 1 or 0, zero-extended.
  - overflow: add sets it when the operand signs are equal and the result sign differs. sub sets it when the operand signs differ and the result sign differs from A. It is 0 for all other operations.
  - Overflow does not suppress RegWrite.
- branch_target: alu_data + (sign_extend_inp << 2), wrapping; the top bits shifted out are dropped.
- write_reg: rd_address when regDest=1, otherwise rt_address.
- Latency: exactly one cycle, inputs to outputs. The block has no combinational input-to-output path.
- Priority on each rising edge (reset is asynchronous and overrides all):
  1. flush: all control outputs (jump_out, MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out, branch_taken_out, zero_out, overflow_out) become 0. Data outputs become 0.
  2. stall: all outputs hold their values.
  3. Otherwise: capture the newly computed values.
- Simultaneous flush and stall: flush wins.
- Continuous stall: outputs stay held indefinitely; input changes have no effect.
- branch_taken_out is computed only from the current instruction's branch and zero; it is never from a stale value.

Test Plan:
- Reset: assert reset mid-cycle with nonzero outputs → all outputs 0 immediately, before the next edge; release → the next edge captures the inputs.
- R-type add: rs=0x7FFFFFFF, rt=1, ALUOp=10, funct=0x20, regDest=1, rd=5, RegWrite=1 → alu_result_out=0x80000000, overflow_out=1, write_reg_out=5, RegWrite_out=1, one cycle later.
- slt: rs=0xFFFFFFFE (−2), rt=3, funct=0x2A → alu_result_out=1. Swapping the operands gives 0.
- beq taken: rs=rt=0x1234, ALUOp=01, branch=1, alu_data=0x100, imm=0xFFFFFFFF → zero_out=1, branch_taken_out=1, branch_target_out=0x000000FC.
- lw: ALUSrc=1, ALUOp=00, rs=0x1000, imm=0x10, regDest=0, rt_address=9, MemRead=1, MemtoReg=1 → alu_result_out=0x1010, write_reg_out=9.
- Stall/flush: stall for 3 cycles while the inputs change → outputs unchanged. Then flush and stall together → all outputs 0. Release both → the next instruction is captured.
